// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package e_mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_NOP   = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Control FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Result of one arithmetic op; wr=0 means HI/LO must keep their values
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  // Ops that occupy the unit for several cycles
  function automatic logic mdu_is_arith(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
module mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output mdu_res_t            res
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, den_s, den_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Products: 64-bit multiply of sign- or zero-extended operands
  always_comb begin
    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    a_zx   = {32'd0, a};
    b_zx   = {32'd0, b};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
  end

  // Divides: signed done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // with zero remainder instead of overflowing; a zero divisor is replaced by 1
  // to keep the datapath defined, and its result is discarded via wr=0.
  always_comb begin
    b_zero = (b == 32'd0);
    a_neg  = a[31];
    b_neg  = b[31];
    a_mag  = a_neg ? (32'd0 - a) : a;
    b_mag  = b_neg ? (32'd0 - b) : b;
    den_s  = b_zero ? 32'd1 : b_mag;
    den_u  = b_zero ? 32'd1 : b;
    q_mag  = a_mag / den_s;
    r_mag  = a_mag % den_s;
    q_s    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_s    = a_neg ? (32'd0 - r_mag) : r_mag;
    q_u    = a / den_u;
    r_u    = a % den_u;
  end

  // Select the result for the decoded op
  always_comb begin
    res = '0;
    case (op)
      MDU_MULT:  begin res.wr = 1'b1;    res.hi = prod_s[63:32]; res.lo = prod_s[31:0]; end
      MDU_MULTU: begin res.wr = 1'b1;    res.hi = prod_u[63:32]; res.lo = prod_u[31:0]; end
      MDU_DIV:   begin res.wr = !b_zero; res.hi = r_s;           res.lo = q_s;          end
      MDU_DIVU:  begin res.wr = !b_zero; res.hi = r_u;           res.lo = q_u;          end
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers, busy FSM, stall request.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op_E,
  input  logic [31:0]         A_E,
  input  logic [31:0]         B_E,
  output logic                busy,
  output logic                stall_req,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  mdu_res_t         calc_res;
  mdu_res_t         pend;
  logic             is_mul;

  mdu_calc u_calc (
    .op  (op_E),
    .a   (A_E),
    .b   (B_E),
    .res (calc_res)
  );

  assign is_mul    = (op_E == MDU_MULT) || (op_E == MDU_MULTU);
  assign busy      = (state == ST_RUN);
  // Only depends on start/op/busy so the hazard unit sees no operand path
  assign stall_req = busy | (start & mdu_is_arith(op_E));

  // Control FSM: capture result at start, count down, commit HI/LO on last cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mdu_is_arith(op_E)) begin
              pend  <= calc_res;
              cnt   <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state <= ST_RUN;
            end else if (op_E == MDU_MTHI) begin
              hi <= A_E;
            end else if (op_E == MDU_MTLO) begin
              lo <= A_E;
            end
          end
        end
        default: begin
          // Any start here is ignored; the hazard unit keeps it from happening
          if (cnt == CNT_W'(1)) begin
            if (pend.wr) begin
              hi <= pend.hi;
              lo <= pend.lo;
            end
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
